// File: rtl/bank_conflict_arbiter.sv
// Two-requester valid/ready front end for a shared dual-port BRAM. Requests that both
// land in the protected window are serialised round-robin; everything else runs in parallel.
// Optional ARB_STATS_EN macro adds the saturating conflict_cnt output.
module bank_conflict_arbiter #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int LOWER_ADDR = 0,
    parameter int UPPER_ADDR = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  mem_a_en,
    output logic                  mem_a_we,
    output logic [ADDR_WIDTH-1:0] mem_a_addr,
    output logic [DATA_WIDTH-1:0] mem_a_wdata,
    input  logic [DATA_WIDTH-1:0] mem_a_rdata,
    output logic                  mem_b_en,
    output logic                  mem_b_we,
    output logic [ADDR_WIDTH-1:0] mem_b_addr,
    output logic [DATA_WIDTH-1:0] mem_b_wdata,
    input  logic [DATA_WIDTH-1:0] mem_b_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]           conflict_cnt
`endif
);

    // Signed, one bit wider, so a zero lower bound does not make the compare constant.
    localparam logic signed [ADDR_WIDTH:0] LO_S = (ADDR_WIDTH+1)'(LOWER_ADDR);
    localparam logic signed [ADDR_WIDTH:0] HI_S = (ADDR_WIDTH+1)'(UPPER_ADDR);

    function automatic logic in_win(input logic [ADDR_WIDTH-1:0] x);
        logic signed [ADDR_WIDTH:0] xs;
        xs = $signed({1'b0, x});
        return (xs >= LO_S) && (xs <= HI_S);
    endfunction

    typedef enum logic {PRIO_A, PRIO_B} prio_t;

    prio_t prio_q, prio_d;
    logic  conflict;

    logic [1:0]                 acc_w;
    logic [1:0]                 we_w;
    logic [1:0][ADDR_WIDTH-1:0] addr_w;
    logic [1:0][DATA_WIDTH-1:0] wdata_w;
    logic [1:0][DATA_WIDTH-1:0] mem_rdata_w;

    assign conflict = a_valid & b_valid & in_win(a_addr) & in_win(b_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= PRIO_A;
        end else begin
            prio_q <= prio_d;
        end
    end

    always_comb begin
        prio_d  = prio_q;
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst) begin
            if (conflict) begin
                a_ready = (prio_q == PRIO_A);
                b_ready = (prio_q == PRIO_B);
                prio_d  = (prio_q == PRIO_A) ? PRIO_B : PRIO_A;
            end else begin
                a_ready = 1'b1;
                b_ready = 1'b1;
            end
        end
    end

    assign acc_w       = {b_valid & b_ready, a_valid & a_ready};
    assign we_w        = {b_we, a_we};
    assign addr_w      = {b_addr, a_addr};
    assign wdata_w     = {b_wdata, a_wdata};
    assign mem_rdata_w = {mem_b_rdata, mem_a_rdata};

    // Identical issue/return pipeline per port: accept -> BRAM command -> read pending -> rdata.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic                  en_q, en_d;
        logic                  we_q, we_d;
        logic [ADDR_WIDTH-1:0] addr_q, addr_d;
        logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
        logic                  pend_q;
        logic                  rvalid_q;
        logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

        always_comb begin
            en_d    = acc_w[gi];
            we_d    = acc_w[gi] & we_w[gi];
            addr_d  = acc_w[gi] ? addr_w[gi] : addr_q;
            wdata_d = acc_w[gi] ? wdata_w[gi] : wdata_q;
            rdata_d = pend_q ? mem_rdata_w[gi] : rdata_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                en_q     <= 1'b0;
                we_q     <= 1'b0;
                addr_q   <= '0;
                wdata_q  <= '0;
                pend_q   <= 1'b0;
                rvalid_q <= 1'b0;
                rdata_q  <= '0;
            end else begin
                en_q     <= en_d;
                we_q     <= we_d;
                addr_q   <= addr_d;
                wdata_q  <= wdata_d;
                pend_q   <= en_q & ~we_q;
                rvalid_q <= pend_q;
                rdata_q  <= rdata_d;
            end
        end
    end

    assign mem_a_en    = g_port[0].en_q;
    assign mem_a_we    = g_port[0].we_q;
    assign mem_a_addr  = g_port[0].addr_q;
    assign mem_a_wdata = g_port[0].wdata_q;
    assign a_rvalid    = g_port[0].rvalid_q;
    assign a_rdata     = g_port[0].rdata_q;

    assign mem_b_en    = g_port[1].en_q;
    assign mem_b_we    = g_port[1].we_q;
    assign mem_b_addr  = g_port[1].addr_q;
    assign mem_b_wdata = g_port[1].wdata_q;
    assign b_rvalid    = g_port[1].rvalid_q;
    assign b_rdata     = g_port[1].rdata_q;

`ifdef ARB_STATS_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (conflict && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_bank_conflict_arbiter.sv
// Scoreboarded bench for bank_conflict_arbiter with a behavioural 1-cycle-latency BRAM.
// Define ARB_STATS_EN to also check conflict_cnt.
module tb_bank_conflict_arbiter;
    localparam int AW = 13;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, a_ready, a_we, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_valid, b_ready, b_we, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          mem_a_en, mem_a_we, mem_b_en, mem_b_we;
    logic [AW-1:0] mem_a_addr, mem_b_addr;
    logic [DW-1:0] mem_a_wdata, mem_b_wdata, mem_a_rdata, mem_b_rdata;
`ifdef ARB_STATS_EN
    logic [31:0]   conflict_cnt;
`endif

    bank_conflict_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_a_en(mem_a_en), .mem_a_we(mem_a_we), .mem_a_addr(mem_a_addr),
        .mem_a_wdata(mem_a_wdata), .mem_a_rdata(mem_a_rdata),
        .mem_b_en(mem_b_en), .mem_b_we(mem_b_we), .mem_b_addr(mem_b_addr),
        .mem_b_wdata(mem_b_wdata), .mem_b_rdata(mem_b_rdata)
`ifdef ARB_STATS_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural BRAM: word i preloaded with 0x1000+i, registered read.
    logic [DW-1:0] ram [256];
    initial begin
        for (int i = 0; i < 256; i++) ram[i] <= 32'h1000 + i;
    end
    always @(posedge clk) begin
        if (mem_a_en) begin
            if (mem_a_we) ram[mem_a_addr[7:0]] <= mem_a_wdata;
            mem_a_rdata <= ram[mem_a_addr[7:0]];
        end
        if (mem_b_en) begin
            if (mem_b_we) ram[mem_b_addr[7:0]] <= mem_b_wdata;
            mem_b_rdata <= ram[mem_b_addr[7:0]];
        end
    end

    typedef struct {
        logic [DW-1:0] d;
        int            c;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Monitor: each read return is matched against the queued data and expected cycle.
    always @(negedge clk) begin
        if (a_rvalid) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                ea = qa.pop_front();
                $display("rd return A data=%h cyc=%0d", a_rdata, cyc);
                chk("a_rdata", a_rdata, ea.d);
                chk("a_rvalid_cycle", cyc, ea.c);
            end
        end
        if (b_rvalid) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                eb = qb.pop_front();
                $display("rd return B data=%h cyc=%0d", b_rdata, cyc);
                chk("b_rdata", b_rdata, eb.d);
                chk("b_rvalid_cycle", cyc, eb.c);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue(input logic av, input logic awe, input logic [AW-1:0] aa,
                         input logic [DW-1:0] ad,
                         input logic bv, input logic bwe, input logic [AW-1:0] ba,
                         input logic [DW-1:0] bd,
                         output logic ag, output logic bg);
        a_valid = av; a_we = awe; a_addr = aa; a_wdata = ad;
        b_valid = bv; b_we = bwe; b_addr = ba; b_wdata = bd;
        @(negedge clk);
        ag = a_valid & a_ready;
        bg = b_valid & b_ready;
        @(posedge clk);
        #1;
        if (ag && !awe) qa.push_back('{ad, cyc + 2});
        if (bg && !bwe) qb.push_back('{bd, cyc + 2});
        $display("issue cyc=%0d A v=%b we=%b addr=%0d grant=%b | B v=%b we=%b addr=%0d grant=%b",
                 cyc, av, awe, aa, ag, bv, bwe, ba, bg);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic          ag, bg;
    int            ia, ib;
    logic [AW-1:0] sa [4];
    logic [AW-1:0] sb [4];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        sa[0] = 13'd0; sa[1] = 13'd1; sa[2] = 13'd3; sa[3] = 13'd4;
        sb[0] = 13'd4; sb[1] = 13'd3; sb[2] = 13'd1; sb[3] = 13'd0;

        // Reset state, ready gated by rst
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_mem_a_en", mem_a_en, 0);
        chk("rst_mem_b_en", mem_b_en, 0);
        chk("rst_a_rvalid", a_rvalid, 0);
        chk("rst_b_rvalid", b_rvalid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_a_ready", a_ready, 1);
        chk("idle_b_ready", b_ready, 1);
        chk("idle_mem_a_en", mem_a_en, 0);
        @(posedge clk);
        #1;

        // Write then read back on port A
        issue(1, 1, 13'd2, 32'hAB, 0, 0, 13'd0, 32'h0, ag, bg);
        chk("wr_grant_a", ag, 1);
        chk("wr_mem_a_en", mem_a_en, 1);
        chk("wr_mem_a_we", mem_a_we, 1);
        chk("wr_mem_a_addr", mem_a_addr, 2);
        chk("wr_mem_a_wdata", mem_a_wdata, 32'hAB);
        chk("wr_mem_b_en", mem_b_en, 0);
        issue(1, 0, 13'd2, 32'hAB, 0, 0, 13'd0, 32'h0, ag, bg);
        chk("rd_grant_a", ag, 1);
        chk("rd_mem_a_en", mem_a_en, 1);
        chk("rd_mem_a_we", mem_a_we, 0);
        idle(4);
        chk("drain_mem_a_en", mem_a_en, 0);
        chk("drain_mem_a_we", mem_a_we, 0);

        // Single conflict: A wins, B held one cycle
        issue(1, 0, 13'd3, 32'h1003, 1, 0, 13'd4, 32'h1004, ag, bg);
        chk("c1_grant_a", ag, 1);
        chk("c1_grant_b", bg, 0);
        chk("c1_mem_b_en", mem_b_en, 0);
        issue(0, 0, 13'd0, 32'h0, 1, 0, 13'd4, 32'h1004, ag, bg);
        chk("c2_grant_b", bg, 1);
        chk("c2_mem_b_en", mem_b_en, 1);
        chk("c2_mem_b_addr", mem_b_addr, 4);
        idle(4);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;

        // Continuous conflicting streams alternate A,B,...
        ia = 0;
        ib = 0;
        for (int k = 0; k < 8; k++) begin
            issue(ia < 4, 0, sa[ia % 4], 32'h1000 + sa[ia % 4],
                  ib < 4, 0, sb[ib % 4], 32'h1000 + sb[ib % 4], ag, bg);
            chk("stream_grant_a", ag, (k % 2 == 0) ? 1 : 0);
            if (k < 7) chk("stream_grant_b", bg, (k % 2 == 1) ? 1 : 0);
            if (ag) ia++;
            if (bg) ib++;
        end
        chk("stream_count_a", ia, 4);
        chk("stream_count_b", ib, 4);
        idle(4);
`ifdef ARB_STATS_EN
        chk("cnt_after_stream", conflict_cnt, 7);
`endif

        // Outside window: parallel issue, returns in the same cycle
        issue(1, 0, 13'd100, 32'h1064, 1, 0, 13'd200, 32'h10C8, ag, bg);
        chk("par_grant_a", ag, 1);
        chk("par_grant_b", bg, 1);
        chk("par_mem_a_addr", mem_a_addr, 100);
        chk("par_mem_b_addr", mem_b_addr, 200);
        issue(1, 0, 13'd100, 32'h1064, 1, 0, 13'd100, 32'h1064, ag, bg);
        chk("same_addr_grant_a", ag, 1);
        chk("same_addr_grant_b", bg, 1);
        // Window edges: 4 is inside, 5 is not
        issue(1, 0, 13'd4, 32'h1004, 1, 0, 13'd5, 32'h1005, ag, bg);
        chk("edge_hi_grant_a", ag, 1);
        chk("edge_hi_grant_b", bg, 1);
        // Last stream conflict was won by A, so B holds priority now
        issue(1, 0, 13'd0, 32'h1000, 1, 0, 13'd0, 32'h1000, ag, bg);
        chk("edge_lo_grant_a", ag, 0);
        chk("edge_lo_grant_b", bg, 1);
        issue(1, 0, 13'd0, 32'h1000, 0, 0, 13'd0, 32'h0, ag, bg);
        chk("edge_lo_retry_a", ag, 1);
        idle(4);
`ifdef ARB_STATS_EN
        chk("cnt_after_edge", conflict_cnt, 8);
`endif

        // Reset right after a read accept discards the return
        issue(1, 0, 13'd1, 32'h1001, 0, 0, 13'd0, 32'h0, ag, bg);
        chk("flush_grant_a", ag, 1);
        if (qa.size() > 0) ea = qa.pop_back();
        rst = 1'b1;
        @(negedge clk);
        chk("flush_a_ready", a_ready, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("flush_a_rvalid", a_rvalid, 0);
        chk("flush_mem_a_en", mem_a_en, 0);
        rst = 1'b0;
        idle(4);
`ifdef ARB_STATS_EN
        chk("cnt_after_rst", conflict_cnt, 0);
`endif

        chk("queues_drained", qa.size() + qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
